cpu_bus_arbiter: RTL and testbench
==================================

// Module: cpu_bus_arbiter
// PURPOSE
//   Shares the Z80 system bus between the CPU and NREQ DMA-style requesters (e.g. SD/DivMMC block transfer, sound DMA)
//   using the BUSRQ/BUSACK handshake. Runs on the stretched/stalled CPU clock, so every count is in CPU T-states.
//   Sequences request -> acknowledge -> grant -> release, picks requesters round-robin, and never starts a new takeover
//   while a maskable INT is about to fire.
// PARAMETERS
//   NREQ        2   number of requesters (1..4)
//   GAP_CYCLES  4   min clkcpu cycles the CPU owns the bus between two grants (>=1)
//   HOLD_MAX    64  max clkcpu cycles per grant (used only with ARB_HOLD_LIMIT_EN)
// PORTS
//   rst_n         in   1     asynchronous, active-low reset
//   clkcpu        in   1     CPU clock; all logic on its rising edge
//   req           in   NREQ  level request per requester, held until grant+done
//   done          in   NREQ  1-cycle pulse: requester finished, release bus
//   n_int_next    in   1     low = INT pulse starting/active; blocks new takeovers
//   n_busack      in   1     Z80 BUSACK (active low)
//   n_busrq       out  1     Z80 BUSRQ (active low), registered
//   grant         out  NREQ  one-hot grant, registered; requester may drive bus only while high
//   bus_busy      out  1     high whenever FSM not in IDLE
//   hold_expired  out  1     1-cycle pulse on forced revoke (tied 0 without macro)
// BEHAVIOUR
//   - Reset: n_busrq=1, grant=0, bus_busy=0, hold_expired=0, state=IDLE, rr pointer=0, counters=0.
//   - n_busack is registered once (ack_q); FSM only uses ack_q.
//   - States: IDLE, REQ, GRANT, RELEASE, GAP.
//   - IDLE: if |req && n_int_next: latch winner (round-robin from pointer, lowest index after last winner first);
//     n_busrq<=0; -> REQ. Latency: req high at edge k -> n_busrq low after edge k+1.
//   - REQ: wait ack_q==0. Then if req[winner] still high: grant[winner]<=1, -> GRANT; else n_busrq<=1,
//     -> RELEASE (no grant). Grant rises 2 edges after CPU drives BUSACK low.
//   - GRANT: hold until done[winner]==1 or req[winner]==0; then grant<=0 and n_busrq<=1 on the same edge,
//     pointer<=winner+1 (mod NREQ), -> RELEASE.
//   - RELEASE: wait ack_q==1, then load gap counter with GAP_CYCLES-1 -> GAP.
//   - GAP: count down; at 0 -> IDLE. New requests ignored during GAP (CPU guaranteed >=GAP_CYCLES progress).
//   - Only one grant bit ever high; grant never high while ack_q==1.
//   - done on a non-granted index is ignored; done and req-drop in the same cycle count as one release.
//   - n_int_next low only gates IDLE->REQ; REQ/GRANT in progress complete normally.
//   - Pointer wraps NREQ-1 -> 0; with a single active requester it is re-granted after every GAP.
//   - rst_n asserted mid-operation: all outputs return to reset values immediately (async); requesters must
//     treat grant fall as abort.
//   - Counter widths $clog2(GAP_CYCLES+1) / $clog2(HOLD_MAX+1); no wrap possible.
// CONFIGURATION
//   ARB_HOLD_LIMIT_EN defined: hold counter cleared at GRANT entry, increments each GRANT cycle; on reaching
//     HOLD_MAX-1 without done, grant<=0, n_busrq<=1, hold_expired<=1 for one cycle, pointer advances,
//     -> RELEASE.
//   Not defined: no hold counter; grant lasts until done/req drop; hold_expired constant 0.
// STRUCTURE
//   Shared package common: typedef enum arb_state_t {ARB_IDLE, ARB_REQ, ARB_GRANT, ARB_RELEASE, ARB_GAP};
//     localparam ARB_NREQ_MAX=4.
//   Sub-module arb_rr_pick: combinational round-robin picker (req, pointer -> one-hot winner + index).
// TESTING
//   1 single req[0] high, CPU model acks 3 cycles after n_busrq low -> grant=01 2 edges after ack; done[0] ->
//     grant=00, n_busrq=1 same edge; next grant no earlier than GAP_CYCLES=4 after ack_q high.
//   2 req=11 held, done pulses each grant -> grants alternate 01,10,01,10; never two bits high.
//   3 req[1] high while n_int_next low -> n_busrq stays 1; n_int_next rises -> n_busrq low next edge.
//   4 req[0] dropped while in REQ -> ack arrives, grant stays 00, n_busrq returns 1, FSM via RELEASE/GAP to IDLE.
//   5 ARB_HOLD_LIMIT_EN, HOLD_MAX=8, no done -> grant high exactly 8 cycles, hold_expired pulse 1 cycle,
//     n_busrq=1; without macro grant held 100+ cycles.
//   6 rst_n low during GRANT -> grant=0, n_busrq=1, bus_busy=0 asynchronously; restart behaves as test 1.

Source files
------------

// File: rtl/cpu_bus_arbiter_pkg.sv
// cpu_bus_arbiter_pkg: FSM state type, requester limit and index-width helper shared by the bus arbiter files.
package cpu_bus_arbiter_pkg;
  typedef enum logic [2:0] {ARB_IDLE, ARB_REQ, ARB_GRANT, ARB_RELEASE, ARB_GAP} arb_state_t;
  localparam int ARB_NREQ_MAX = 4;
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/cpu_bus_arbiter_rr_pick.sv
// arb_rr_pick: combinational round-robin picker; searches upward from ptr_i and wraps to 0.
module arb_rr_pick
  import cpu_bus_arbiter_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0]        req_i,
  input  logic [idx_w(NREQ)-1:0] ptr_i,
  output logic [NREQ-1:0]        win_oh_o,
  output logic [idx_w(NREQ)-1:0] win_idx_o,
  output logic                   any_o
);
  localparam int IW = idx_w(NREQ);
  logic [IW-1:0] j;
  assign any_o = |req_i;
  // Walk from the farthest candidate down so the nearest one to ptr_i is written last.
  always_comb begin
    j = '0;
    win_oh_o = '0;
    win_idx_o = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      j = IW'((int'(ptr_i) + i) % NREQ);
      win_idx_o = req_i[j] ? j : win_idx_o;
    end
    win_oh_o[win_idx_o] = any_o;
  end
endmodule

// File: rtl/cpu_bus_arbiter.sv
// cpu_bus_arbiter: BUSRQ/BUSACK bus sharing between the Z80 and NREQ DMA requesters, round-robin.
// ARB_HOLD_LIMIT_EN adds a per-grant cycle limit that forcibly revokes the bus and pulses hold_expired_o.
module cpu_bus_arbiter
  import cpu_bus_arbiter_pkg::*;
#(
  parameter int NREQ       = 2,
  parameter int GAP_CYCLES = 4,
  parameter int HOLD_MAX   = 64
) (
  input  logic            rst_n,
  input  logic            clkcpu,
  input  logic [NREQ-1:0] req_i,
  input  logic [NREQ-1:0] done_i,
  input  logic            n_int_next_i,
  input  logic            n_busack_i,
  output logic            n_busrq_o,
  output logic [NREQ-1:0] grant_o,
  output logic            bus_busy_o,
  output logic            hold_expired_o
);
  localparam int IW = idx_w(NREQ);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  arb_state_t      state_q, state_d;
  logic            ack_q;
  logic            n_busrq_q, n_busrq_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [NREQ-1:0] sel_q, sel_d;
  logic [IW-1:0]   win_q, win_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic [NREQ-1:0] pick_oh;
  logic [IW-1:0]   pick_idx;
  logic            pick_any;
  logic            rel;
  logic            expire;
  logic [IW-1:0]   ptr_nxt;

  arb_rr_pick #(.NREQ(NREQ)) u_pick (
    .req_i    (req_i),
    .ptr_i    (ptr_q),
    .win_oh_o (pick_oh),
    .win_idx_o(pick_idx),
    .any_o    (pick_any)
  );

  // A done pulse and a dropped request in the same cycle are the same single release.
  assign rel = |(done_i & sel_q) || !(|(req_i & sel_q));
  assign ptr_nxt = (win_q == IW'(NREQ - 1)) ? '0 : win_q + 1'b1;

`ifdef ARB_HOLD_LIMIT_EN
  localparam int HW = $clog2(HOLD_MAX + 1);
  logic [HW-1:0] hold_q;
  logic          hexp_q;
  assign expire = hold_q == HW'(HOLD_MAX - 1);
  always_ff @(posedge clkcpu or negedge rst_n)
    if (!rst_n) begin
      hold_q <= '0;
      hexp_q <= 1'b0;
    end else begin
      hold_q <= (state_q == ARB_GRANT) ? hold_q + 1'b1 : '0;
      hexp_q <= (state_q == ARB_GRANT) && expire && !rel;
    end
  assign hold_expired_o = hexp_q;
`else
  assign expire = 1'b0;
  assign hold_expired_o = 1'b0;
`endif

  always_ff @(posedge clkcpu or negedge rst_n)
    if (!rst_n) begin
      state_q   <= ARB_IDLE;
      ack_q     <= 1'b1;
      n_busrq_q <= 1'b1;
      grant_q   <= '0;
      sel_q     <= '0;
      win_q     <= '0;
      ptr_q     <= '0;
      gap_q     <= '0;
    end else begin
      state_q   <= state_d;
      ack_q     <= n_busack_i;
      n_busrq_q <= n_busrq_d;
      grant_q   <= grant_d;
      sel_q     <= sel_d;
      win_q     <= win_d;
      ptr_q     <= ptr_d;
      gap_q     <= gap_d;
    end

  always_comb begin
    state_d = state_q;
    n_busrq_d = n_busrq_q;
    grant_d = grant_q;
    sel_d = sel_q;
    win_d = win_q;
    ptr_d = ptr_q;
    gap_d = gap_q;
    case (state_q)
      ARB_IDLE:
        if (pick_any && n_int_next_i) begin
          sel_d = pick_oh;
          win_d = pick_idx;
          n_busrq_d = 1'b0;
          state_d = ARB_REQ;
        end
      ARB_REQ:
        if (!ack_q) begin
          grant_d = (|(req_i & sel_q)) ? sel_q : '0;
          n_busrq_d = !(|(req_i & sel_q));
          state_d = (|(req_i & sel_q)) ? ARB_GRANT : ARB_RELEASE;
        end
      ARB_GRANT:
        if (rel || expire) begin
          grant_d = '0;
          n_busrq_d = 1'b1;
          ptr_d = ptr_nxt;
          state_d = ARB_RELEASE;
        end
      ARB_RELEASE:
        if (ack_q) begin
          gap_d = GW'(GAP_CYCLES - 1);
          state_d = ARB_GAP;
        end
      ARB_GAP: begin
        gap_d = (gap_q == '0) ? gap_q : gap_q - 1'b1;
        state_d = (gap_q == '0) ? ARB_IDLE : ARB_GAP;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  assign n_busrq_o = n_busrq_q;
  assign grant_o = grant_q;
  assign bus_busy_o = state_q != ARB_IDLE;
endmodule

// File: tb/tb_cpu_bus_arbiter.sv
// tb_cpu_bus_arbiter: directed bench with a Z80 BUSACK model and a grant-order scoreboard.
module tb_cpu_bus_arbiter;
`ifdef ARB_HOLD_LIMIT_EN
  localparam int HOLD = 8;
`else
  localparam int HOLD = 64;
`endif
  logic       clkcpu = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] req = 2'b00;
  logic [1:0] done = 2'b00;
  logic       n_int_next = 1'b1;
  logic       n_busack = 1'b1;
  logic       n_busrq, bus_busy, hold_expired;
  logic [1:0] grant;
  logic [2:0] ack_sr = 3'b111;
  logic [1:0] prev_grant = 2'b00;
  logic [1:0] exp_q[$];
  int         checks = 0;
  int         failures = 0;
  int         n;

  always #5 clkcpu = ~clkcpu;

  cpu_bus_arbiter #(.NREQ(2), .GAP_CYCLES(4), .HOLD_MAX(HOLD)) dut (
    .rst_n         (rst_n),
    .clkcpu        (clkcpu),
    .req_i         (req),
    .done_i        (done),
    .n_int_next_i  (n_int_next),
    .n_busack_i    (n_busack),
    .n_busrq_o     (n_busrq),
    .grant_o       (grant),
    .bus_busy_o    (bus_busy),
    .hold_expired_o(hold_expired)
  );

  // CPU model: BUSACK follows BUSRQ three cycles later, updated on the falling edge.
  always @(negedge clkcpu or negedge rst_n) begin
    ack_sr = rst_n ? {ack_sr[1:0], n_busrq} : 3'b111;
    n_busack = ack_sr[2];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  always @(negedge clkcpu) begin
    if (rst_n) begin
      chk("grant_onehot", 32'($countones(grant)), 32'd1 - 32'(grant == 2'b00));
      if (grant != 2'b00 && prev_grant == 2'b00) begin
        if (exp_q.size() == 0) chk("grant_unexpected", grant, 0);
        else chk("grant_order", grant, exp_q.pop_front());
      end
    end
    prev_grant = grant;
  end

  task automatic tick(input int k);
    repeat (k) @(posedge clkcpu);
    #1;
  endtask

  function automatic logic cond(input int sel);
    case (sel)
      0: return grant != 2'b00;
      1: return n_busrq == 1'b0;
      2: return n_busrq == 1'b1;
      3: return n_busack == 1'b0;
      4: return n_busack == 1'b1;
      6: return grant == 2'b00;
      default: return !bus_busy;
    endcase
  endfunction

  task automatic wait_until(input int sel, input int max, input string tag, output int cnt);
    cnt = 0;
    while (!cond(sel) && cnt < max) begin
      tick(1);
      cnt++;
    end
    checks++;
    assert (cond(sel)) else begin
      failures++;
      $error("FAIL %s timeout after %0d cycles observed=0 expected=1", tag, cnt);
    end
  endtask

  task automatic release_grant(input logic [1:0] d, input logic [1:0] r, input string tag);
    done = d;
    req = r;
    tick(1);
    done = 2'b00;
    chk(tag, {grant, n_busrq}, 3'b001);
  endtask

  initial begin
    tick(2);
    chk("rst_busrq", n_busrq, 1);
    chk("rst_grant", grant, 0);
    chk("rst_busy", bus_busy, 0);
    chk("rst_hexp", hold_expired, 0);
    rst_n = 1'b1;
    // Test 1: single requester, exact request/grant/release/gap timing.
    req = 2'b01;
    tick(1);
    chk("t1_busrq_low", n_busrq, 0);
    chk("t1_busy", bus_busy, 1);
    exp_q.push_back(2'b01);
    wait_until(3, 20, "t1_busack", n);
    chk("t1_grant_early", grant, 0);
    tick(1);
    chk("t1_grant", grant, 2'b01);
    tick(3);
    chk("t1_grant_held", grant, 2'b01);
    release_grant(2'b01, 2'b00, "t1_release");
    wait_until(4, 20, "t1_busack_high", n);
    req = 2'b01;
    wait_until(1, 20, "t1_rereq", n);
    chk("t1_gap_latency", n, 6);
    exp_q.push_back(2'b01);
    wait_until(0, 20, "t1_grant2", n);
    tick(1);
    release_grant(2'b01, 2'b00, "t1_release2");
    wait_until(7, 30, "t1_idle", n);
    // Test 3: pending INT blocks a new takeover.
    n_int_next = 1'b0;
    req = 2'b10;
    tick(5);
    chk("t3_blocked_busrq", n_busrq, 1);
    chk("t3_blocked_busy", bus_busy, 0);
    n_int_next = 1'b1;
    tick(1);
    chk("t3_busrq_low", n_busrq, 0);
    exp_q.push_back(2'b10);
    wait_until(0, 20, "t3_grant", n);
    release_grant(2'b10, 2'b00, "t3_release");
    wait_until(7, 30, "t3_idle", n);
    // Test 2: two requesters held, alternating grants.
    req = 2'b11;
    exp_q.push_back(2'b01);
    exp_q.push_back(2'b10);
    exp_q.push_back(2'b01);
    exp_q.push_back(2'b10);
    for (int k = 0; k < 4; k++) begin
      wait_until(0, 40, "t2_grant", n);
      tick(2);
      release_grant(k[0] ? 2'b10 : 2'b01, k == 3 ? 2'b00 : 2'b11, "t2_release");
    end
    wait_until(7, 30, "t2_idle", n);
    chk("t2_all_granted", exp_q.size(), 0);
    // Test 4: request withdrawn before BUSACK.
    req = 2'b01;
    tick(1);
    chk("t4_busrq_low", n_busrq, 0);
    tick(1);
    req = 2'b00;
    wait_until(2, 20, "t4_busrq_release", n);
    chk("t4_no_grant", grant, 0);
    wait_until(7, 30, "t4_idle", n);
    chk("t4_no_grant_idle", grant, 0);
    // Test 5: long grant, with or without the hold limit.
    req = 2'b01;
    exp_q.push_back(2'b01);
    wait_until(0, 20, "t5_grant", n);
`ifdef ARB_HOLD_LIMIT_EN
    wait_until(6, 200, "t5_revoke", n);
    chk("t5_hold_len", n, HOLD);
    chk("t5_hexp_pulse", hold_expired, 1);
    chk("t5_busrq_high", n_busrq, 1);
    req = 2'b00;
    tick(1);
    chk("t5_hexp_clear", hold_expired, 0);
`else
    tick(100);
    chk("t5_grant_held", grant, 2'b01);
    chk("t5_no_hexp", hold_expired, 0);
    release_grant(2'b01, 2'b00, "t5_release");
`endif
    wait_until(7, 30, "t5_idle", n);
    // Test 6: asynchronous reset during a grant, then restart.
    req = 2'b01;
    exp_q.push_back(2'b01);
    wait_until(0, 20, "t6_grant", n);
    tick(2);
    rst_n = 1'b0;
    req = 2'b00;
    #1;
    chk("t6_async_grant", grant, 0);
    chk("t6_async_busrq", n_busrq, 1);
    chk("t6_async_busy", bus_busy, 0);
    tick(2);
    rst_n = 1'b1;
    req = 2'b01;
    tick(1);
    chk("t6_busrq_low", n_busrq, 0);
    exp_q.push_back(2'b01);
    wait_until(3, 20, "t6_busack", n);
    chk("t6_grant_early", grant, 0);
    tick(1);
    chk("t6_grant", grant, 2'b01);
    release_grant(2'b01, 2'b00, "t6_release");
    wait_until(7, 30, "t6_idle", n);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
